// File: rtl/alu_pkg.sv
// Shared ALU opcodes, default datapath width and multiply-sequencer state encoding.
// Imported by the multiply sequencer and the ALU share mux.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b1010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_share_mux.sv
// Selects who drives the shared ALU: the execute datapath, or the multiply sequencer while it runs.
// Latency: purely combinational. Backpressure: none; ownership is decided by the caller's run flag.
// Only one owner at a time, so there is no arbitration state here.
module alu_share_mux
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              run,
    input  logic [3:0]        ex_alu_op,
    input  logic [DATA_W-1:0] ex_a,
    input  logic [DATA_W-1:0] ex_b,
    input  logic [3:0]        seq_alu_op,
    input  logic [DATA_W-1:0] seq_a,
    input  logic [DATA_W-1:0] seq_b,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b
);

    assign alu_op = run ? seq_alu_op : ex_alu_op;
    assign alu_a  = run ? seq_a      : ex_a;
    assign alu_b  = run ? seq_b      : ex_b;

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier producing the low DATA_W product bits by borrowing the shared ALU for accumulates.
// Latency: DATA_W cycles accept-to-rsp_valid (MUL_EARLY_EXIT_EN: highest set bit of req_b plus one).
// Backpressure: one op in flight; req_ready only in IDLE, product held in DONE until rsp_ready.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_prod,
    output logic              rsp_zero,
    input  logic [3:0]        ex_alu_op,
    input  logic [DATA_W-1:0] ex_a,
    input  logic [DATA_W-1:0] ex_b,
    output logic              ex_stall,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result
);

    mul_state_t        state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] prod_q;
    logic              zero_q;

    logic              run;
    logic [DATA_W-1:0] acc_nxt;
    logic              run_last;

    assign run       = (state == RUN);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign ex_stall  = run;
    assign rsp_prod  = prod_q;
    assign rsp_zero  = zero_q;

    // The ALU computes acc + mcand; only keep it when this multiplier bit is set.
    assign acc_nxt = mplier[0] ? alu_result : acc;

`ifdef MUL_EARLY_EXIT_EN
    assign run_last = (cnt == CNT_W'(DATA_W - 1)) || ((mplier >> 1) == '0);
`else
    assign run_last = (cnt == CNT_W'(DATA_W - 1));
`endif

    alu_share_mux #(
        .DATA_W (DATA_W)
    ) u_alu_share_mux (
        .run        (run),
        .ex_alu_op  (ex_alu_op),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .seq_alu_op (ALU_ADD),
        .seq_a      (acc),
        .seq_b      (mcand),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            prod_q <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        acc    <= '0;
                        mcand  <= req_a;
                        mplier <= req_b;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (run_last) begin
                        prod_q <= acc_nxt;
                        zero_q <= (acc_nxt == '0);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: driver pushes hand-computed products, monitor pops on each response.
// A small behavioural ALU closes the loop on alu_op/alu_a/alu_b -> alu_result.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_prod;
    logic        rsp_zero;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        ex_stall;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    typedef struct {
        logic [31:0] prod;
        logic        zero;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   n_rsp = 0;
    bit   ex_fixed = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mul_seq u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_prod   (rsp_prod),
        .rsp_zero   (rsp_zero),
        .ex_alu_op  (ex_alu_op),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_stall   (ex_stall),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0010: alu_result = alu_a - alu_b;
            4'b1010: alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
            4'b0100: alu_result = alu_a & alu_b;
            4'b0101: alu_result = alu_a | alu_b;
            4'b0110: alu_result = alu_a ^ alu_b;
            4'b0111: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int lat_of(input int early);
`ifdef MUL_EARLY_EXIT_EN
        return early;
`else
        return (early >= 0) ? 32 : 32;
`endif
    endfunction

    // Datapath traffic: random while nobody cares, a fixed SUB during the backpressure window.
    always @(negedge clk) begin
        if (ex_fixed) begin
            ex_alu_op = 4'b0010;
            ex_a      = 32'd10;
            ex_b      = 32'd3;
        end else begin
            ex_alu_op = 4'($urandom_range(0, 15));
            ex_a      = $urandom;
            ex_b      = $urandom;
        end
    end

    // Monitor: ALU ownership every cycle, plus scoreboard pop on each response handshake.
    int   stall_cnt = 0;
    int   bad_op = 0;
    int   rise_cyc = 0;
    bit   prev_valid = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            stall_cnt  = 0;
            bad_op     = 0;
            prev_valid = 1'b0;
        end else begin
            if (ex_stall) begin
                stall_cnt++;
                if (alu_op != 4'b0000) bad_op++;
            end else begin
                check("passthru", {alu_op, alu_a, alu_b}, {ex_alu_op, ex_a, ex_b});
            end
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 68'(rsp_prod), 68'hx);
                end else begin
                    e = sb.pop_front();
                    check("prod", 68'(rsp_prod), 68'(e.prod));
                    check("zero", 68'(rsp_zero), 68'(e.zero));
                    check("latency", 68'(rise_cyc - e.acc), 68'(e.lat));
                    check("stall_len", 68'(stall_cnt), 68'(e.lat));
                    check("run_alu_op", 68'(bad_op), 68'd0);
                end
                stall_cnt = 0;
                bad_op    = 0;
                n_rsp++;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prod, input logic zero, input int early);
        exp_t x;
        int   n;
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 68'(n < 200), 68'd1);
        x.prod = prod;
        x.zero = zero;
        x.lat  = lat_of(early);
        x.acc  = cyc + 1;
        sb.push_back(x);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 68'(n < 300), 68'd1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", 68'(rsp_valid), 68'd0);
        check("rst_rsp_prod", 68'(rsp_prod), 68'd0);
        check("rst_rsp_zero", 68'(rsp_zero), 68'd0);
        check("rst_ex_stall", 68'(ex_stall), 68'd0);
        check("rst_req_ready", 68'(req_ready), 68'd1);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'd6, 32'd7, 32'd42, 1'b0, 3);
        drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32);
        drain();
        issue(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 17);
        drain();

        // Backpressure: product must hold while the ALU serves the datapath.
        rsp_ready = 1'b0;
        ex_fixed  = 1'b1;
        issue(32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, 5);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("bp_rsp_timeout", 68'(rsp_valid), 68'd1);
        repeat (5) begin
            @(negedge clk);
            #1;
            check("bp_prod", 68'(rsp_prod), 68'h1_2340);
            check("bp_zero", 68'(rsp_zero), 68'd0);
            check("bp_req_ready", 68'(req_ready), 68'd0);
            check("bp_ex_stall", 68'(ex_stall), 68'd0);
        end
        rsp_ready = 1'b1;
        drain();
        ex_fixed = 1'b0;

        // Reset during RUN cycle 10: the op is abandoned.
        issue(32'h0000_0011, 32'hFFFF_FFFF, 32'hFFFF_FFEF, 1'b0, 32);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 68'(rsp_valid), 68'd0);
        check("midrst_ex_stall", 68'(ex_stall), 68'd0);
        check("midrst_req_ready", 68'(req_ready), 68'd1);
        check("midrst_rsp_prod", 68'(rsp_prod), 68'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd3, 32'd5, 32'd15, 1'b0, 3);
        drain();

        // A req_valid pulse during RUN must be ignored.
        issue(32'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32);
        repeat (4) @(negedge clk);
        req_valid = 1'b1;
        req_a     = 32'd9;
        req_b     = 32'd9;
        #1;
        check("run_req_ready", 68'(req_ready), 68'd0);
        @(negedge clk);
        req_valid = 1'b0;
        drain();

        // Back-to-back requests with early-exit-sensitive multipliers.
        issue(32'h0000_DEAD, 32'd3, 32'h0002_9C07, 1'b0, 2);
        issue(32'h1234_5678, 32'd0, 32'h0, 1'b1, 1);
        issue(32'd5, 32'h8000_0000, 32'h8000_0000, 1'b0, 32);
        issue(32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b0, 2);
        drain();

        repeat (3) @(negedge clk);
        #2;
        check("sb_empty", 68'(sb.size()), 68'd0);
        check("rsp_count", 68'(n_rsp), 68'd10);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
